// File: rtl/regfile_pkg.sv
// Shared constants, clear-sequencer state type and the logical-to-physical
// register mapping used by the banked register file.
package regfile_pkg;

  localparam int DEF_DATA_W      = 4;
  localparam int DEF_NUM_REGS    = 16;
  localparam int DEF_NUM_BANKS   = 2;
  localparam int DEF_BANKED_REGS = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Low indices live in a per-bank slice; high indices sit after the last
  // bank slice and are shared by every bank view.
  function automatic int physIndex(input int addr, input int bank,
                                   input int banked_regs, input int num_banks);
    if (addr < banked_regs) begin
      return (bank % num_banks) * banked_regs + addr;
    end
    return banked_regs * (num_banks - 1) + addr;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear-all sequencer: sweeps every physical entry once, one per cycle,
// and flags the end of the sweep with a single-cycle pulse.
module rf_clear_seq
  import regfile_pkg::*;
#(
  parameter int PHYS_REGS = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             clrReq_i,
  output logic             clrActive_o,
  output logic [IDX_W-1:0] clrIdx_o,
  output logic             clrDone_o,
  output clr_state_e       state_o
);

  clr_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clrReq_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // clrReq is ignored here; a sweep always runs to completion
        if (cnt_q == IDX_W'(PHYS_REGS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clrActive_o = (state_q == CLEAR);
  assign clrIdx_o    = cnt_q;
  assign clrDone_o   = done_q;
  assign state_o     = state_q;

endmodule

// File: rtl/banked_register_file.sv
// Index register file with bank-switched low registers, prioritised
// single/increment/pair writes and a multi-cycle clear-all sweep.
module banked_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int NUM_BANKS   = DEF_NUM_BANKS,
  parameter int BANKED_REGS = DEF_BANKED_REGS,
  localparam int ADDR_W     = $clog2(NUM_REGS),
  localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                bankWe,
  input  logic [BANK_W-1:0]   bankSel,
  output logic [BANK_W-1:0]   curBank,
  input  logic                regWe,
  input  logic                incEn,
  input  logic [ADDR_W-1:0]   regAddr,
  input  logic [DATA_W-1:0]   regDin,
  output logic [DATA_W-1:0]   regDout,
  output logic                incWrap,
  input  logic                pairWe,
  input  logic [ADDR_W-1:0]   pairAddr,
  input  logic [2*DATA_W-1:0] pairDin,
  output logic [2*DATA_W-1:0] pairDout,
  input  logic                clrReq,
  output logic                busy,
  output logic                clrDone
);

  localparam int PHYS_REGS = BANKED_REGS * NUM_BANKS + NUM_REGS - BANKED_REGS;
  localparam int PHYS_W    = (PHYS_REGS > 1) ? $clog2(PHYS_REGS) : 1;

  logic [DATA_W-1:0] regs_q [PHYS_REGS];
  logic [DATA_W-1:0] regs_d [PHYS_REGS];
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              wrap_q, wrap_d;

  logic              clr_active;
  logic [PHYS_W-1:0] clr_idx;
  clr_state_e        clr_state;

  logic [ADDR_W-1:0] pair_even, pair_odd;
  logic [PHYS_W-1:0] reg_pi, even_pi, odd_pi;

  rf_clear_seq #(
    .PHYS_REGS(PHYS_REGS),
    .IDX_W    (PHYS_W)
  ) u_clear_seq (
    .clk        (clk),
    .rstN       (rstN),
    .clrReq_i   (clrReq),
    .clrActive_o(clr_active),
    .clrIdx_o   (clr_idx),
    .clrDone_o  (clrDone),
    .state_o    (clr_state)
  );

  // Pair accesses always start on an even index so they never straddle pairs
  assign pair_even = pairAddr & ~ADDR_W'(1);
  assign pair_odd  = pair_even | ADDR_W'(1);

  assign reg_pi  = PHYS_W'(physIndex(int'(regAddr), int'(bank_q), BANKED_REGS, NUM_BANKS));
  assign even_pi = PHYS_W'(physIndex(int'(pair_even), int'(bank_q), BANKED_REGS, NUM_BANKS));
  assign odd_pi  = PHYS_W'(physIndex(int'(pair_odd), int'(bank_q), BANKED_REGS, NUM_BANKS));

  // Later assignments override earlier ones: regWe > incEn > pairWe
  always_comb begin
    regs_d = regs_q;
    if (clr_active) begin
      regs_d[clr_idx] = '0;
    end else begin
      if (pairWe) begin
        regs_d[even_pi] = pairDin[2*DATA_W-1:DATA_W];
        regs_d[odd_pi]  = pairDin[DATA_W-1:0];
      end
      if (incEn) regs_d[reg_pi] = regs_q[reg_pi] + DATA_W'(1);
      if (regWe) regs_d[reg_pi] = regDin;
    end
  end

  always_comb begin
    bank_d = bank_q;
    if (!clr_active && bankWe) bank_d = bankSel;
    wrap_d = !clr_active && incEn && !regWe && (regs_q[reg_pi] == '1);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < PHYS_REGS; i++) regs_q[i] <= '0;
      bank_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      bank_q <= bank_d;
      wrap_q <= wrap_d;
    end
  end

  assign curBank  = bank_q;
  assign incWrap  = wrap_q;
  assign busy     = (clr_state == CLEAR);
  assign regDout  = regs_q[reg_pi];
  assign pairDout = {regs_q[even_pi], regs_q[odd_pi]};

endmodule

// File: tb/tb_banked_register_file.sv
// Directed bench for banked_register_file with a queued scoreboard of
// expected values and immediate assertions at each comparison point.
module tb_banked_register_file;

  logic       clk;
  logic       rstN;
  logic       bankWe;
  logic [0:0] bankSel;
  logic [0:0] curBank;
  logic       regWe;
  logic       incEn;
  logic [3:0] regAddr;
  logic [3:0] regDin;
  logic [3:0] regDout;
  logic       incWrap;
  logic       pairWe;
  logic [3:0] pairAddr;
  logic [7:0] pairDin;
  logic [7:0] pairDout;
  logic       clrReq;
  logic       busy;
  logic       clrDone;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [3:0] model[24];

  banked_register_file dut (
    .clk     (clk),
    .rstN    (rstN),
    .bankWe  (bankWe),
    .bankSel (bankSel),
    .curBank (curBank),
    .regWe   (regWe),
    .incEn   (incEn),
    .regAddr (regAddr),
    .regDin  (regDin),
    .regDout (regDout),
    .incWrap (incWrap),
    .pairWe  (pairWe),
    .pairAddr(pairAddr),
    .pairDin (pairDin),
    .pairDout(pairDout),
    .clrReq  (clrReq),
    .busy    (busy),
    .clrDone (clrDone)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pidx(input int b, input int a);
    return (a < 8) ? b * 8 + a : 8 + a;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    regWe  = 1'b0;
    incEn  = 1'b0;
    pairWe = 1'b0;
    bankWe = 1'b0;
    clrReq = 1'b0;
  endtask

  task automatic set_bank(input logic [0:0] b);
    bankWe  = 1'b1;
    bankSel = b;
    tick();
    bankWe  = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    regWe   = 1'b1;
    regAddr = a;
    regDin  = d;
    tick();
    regWe   = 1'b0;
  endtask

  // Scoreboard
  task automatic push_exp(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [3:0] e);
    push_exp({4'h0, e});
    regAddr = a;
    @(negedge clk);
    check(tag, {4'h0, regDout});
  endtask

  task automatic pair_chk(input string tag, input logic [3:0] a, input logic [7:0] e);
    push_exp(e);
    pairAddr = a;
    @(negedge clk);
    check(tag, pairDout);
  endtask

  task automatic all_zero_chk(input string tag);
    for (int b = 0; b < 2; b++) begin
      set_bank(b[0:0]);
      for (int r = 0; r < 16; r++) read_chk(tag, r[3:0], 4'h0);
    end
  endtask

  initial begin
    int   busy_cycles;
    logic done_early;
    logic done_seen;
    logic [3:0] d;

    rstN     = 1'b0;
    idle_inputs();
    bankSel  = '0;
    regAddr  = '0;
    regDin   = '0;
    pairAddr = '0;
    pairDin  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;

    // Reset state
    push_exp(8'h00); check("rst_curBank", {7'b0, curBank});
    push_exp(8'h00); check("rst_busy", {7'b0, busy});
    push_exp(8'h00); check("rst_clrDone", {7'b0, clrDone});
    push_exp(8'h00); check("rst_incWrap", {7'b0, incWrap});
    read_chk("rst_reg0", 4'd0, 4'h0);
    pair_chk("rst_pair0", 4'd0, 8'h00);

    // Banked vs shared registers
    wr(4'd3, 4'hA);
    read_chk("b0_r3", 4'd3, 4'hA);
    set_bank(1'b1);
    push_exp(8'h01); check("bank_now_1", {7'b0, curBank});
    read_chk("b1_r3", 4'd3, 4'h0);
    set_bank(1'b0);
    read_chk("b0_r3_back", 4'd3, 4'hA);
    set_bank(1'b1);
    wr(4'd12, 4'h5);
    read_chk("b1_r12", 4'd12, 4'h5);
    set_bank(1'b0);
    read_chk("b0_r12_shared", 4'd12, 4'h5);

    // Write in the bankWe cycle lands in the old bank
    regWe = 1'b1; regAddr = 4'd1; regDin = 4'h6; bankWe = 1'b1; bankSel = 1'b1;
    tick();
    idle_inputs();
    read_chk("oldbank_b1_r1", 4'd1, 4'h0);
    set_bank(1'b0);
    read_chk("oldbank_b0_r1", 4'd1, 4'h6);

    // Pair write at an odd address
    pairWe = 1'b1; pairAddr = 4'd5; pairDin = 8'h7C;
    tick();
    idle_inputs();
    read_chk("pair_r4", 4'd4, 4'h7);
    read_chk("pair_r5", 4'd5, 4'hC);
    pair_chk("pair_rd4", 4'd4, 8'h7C);
    pair_chk("pair_rd5", 4'd5, 8'h7C);

    // regWe beats pairWe on the overlapping register
    regWe = 1'b1; regAddr = 4'd4; regDin = 4'h1;
    pairWe = 1'b1; pairAddr = 4'd4; pairDin = 8'h99;
    tick();
    idle_inputs();
    read_chk("prio_r4", 4'd4, 4'h1);
    read_chk("prio_r5", 4'd5, 4'h9);

    // Increment with wrap
    wr(4'd2, 4'hF);
    incEn = 1'b1; regAddr = 4'd2;
    tick();
    idle_inputs();
    push_exp(8'h01); check("inc_wrap_set", {7'b0, incWrap});
    read_chk("inc_r2_0", 4'd2, 4'h0);
    incEn = 1'b1; regAddr = 4'd2;
    tick();
    idle_inputs();
    push_exp(8'h00); check("inc_wrap_clr", {7'b0, incWrap});
    read_chk("inc_r2_1", 4'd2, 4'h1);

    // regWe with incEn on the same register: write wins, no wrap
    regWe = 1'b1; incEn = 1'b1; regAddr = 4'd2; regDin = 4'hF;
    tick();
    idle_inputs();
    push_exp(8'h00); check("we_inc_wrap", {7'b0, incWrap});
    read_chk("we_inc_r2", 4'd2, 4'hF);

    // incEn beats pairWe on the overlapping register
    incEn = 1'b1; regAddr = 4'd2; pairWe = 1'b1; pairAddr = 4'd2; pairDin = 8'h33;
    tick();
    idle_inputs();
    push_exp(8'h01); check("inc_pair_wrap", {7'b0, incWrap});
    read_chk("inc_pair_r2", 4'd2, 4'h0);
    read_chk("inc_pair_r3", 4'd3, 4'h3);

    // Fill every register in both banks
    for (int b = 0; b < 2; b++) begin
      set_bank(b[0:0]);
      for (int r = 0; r < 16; r++) begin
        d = 4'($urandom_range(1, 15));
        wr(r[3:0], d);
        model[pidx(b, r)] = d;
      end
    end
    for (int b = 0; b < 2; b++) begin
      set_bank(b[0:0]);
      for (int r = 0; r < 16; r++) read_chk("fill_rd", r[3:0], model[pidx(b, r)]);
    end

    // Clear sweep; bank 1 is active, writes/bank/clrReq during busy ignored
    clrReq = 1'b1;
    tick();
    clrReq = 1'b0;
    push_exp(8'h01); check("clr_busy_rise", {7'b0, busy});
    busy_cycles = 0;
    done_early  = 1'b0;
    while (busy === 1'b1 && busy_cycles < 100) begin
      if (clrDone) done_early = 1'b1;
      regWe   = (busy_cycles == 20);
      regAddr = 4'd0;
      regDin  = 4'hE;
      bankWe  = (busy_cycles == 21);
      bankSel = 1'b0;
      clrReq  = (busy_cycles == 22);
      busy_cycles++;
      tick();
    end
    idle_inputs();
    push_exp(8'd24); check("clr_busy_cycles", 8'(busy_cycles));
    push_exp(8'h00); check("clr_no_early_done", {7'b0, done_early});
    push_exp(8'h01); check("clr_done_pulse", {7'b0, clrDone});
    push_exp(8'h01); check("clr_bank_kept", {7'b0, curBank});
    tick();
    push_exp(8'h00); check("clr_done_one_cycle", {7'b0, clrDone});
    push_exp(8'h00); check("clr_no_restart", {7'b0, busy});
    all_zero_chk("clr_zero");

    // Reset in the middle of a sweep
    set_bank(1'b1);
    wr(4'd0, 4'h9);
    wr(4'd9, 4'h3);
    clrReq = 1'b1;
    tick();
    clrReq = 1'b0;
    repeat (9) tick();
    #2;
    rstN = 1'b0;
    #1;
    push_exp(8'h00); check("midrst_busy", {7'b0, busy});
    push_exp(8'h00); check("midrst_clrDone", {7'b0, clrDone});
    push_exp(8'h00); check("midrst_curBank", {7'b0, curBank});
    @(negedge clk);
    rstN = 1'b1;
    done_seen = 1'b0;
    repeat (30) begin
      tick();
      if (clrDone) done_seen = 1'b1;
    end
    push_exp(8'h00); check("midrst_no_done", {7'b0, done_seen});
    push_exp(8'h00); check("midrst_idle", {7'b0, busy});
    all_zero_chk("midrst_zero");

    // Final report
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL leftover_expected: observed %0d queued, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
